// File: rtl/nco_pkg.sv
// Shared types, latency constant and quarter-wave table generator for the NCO.
// Table entries are sampled at bin centres, so folding needs no endpoint entry.
package nco_pkg;

    typedef logic [1:0] quad_t;

    localparam int unsigned NCO_LAT = 4;

    // pi/2 in Q30; integer Taylor series keeps ROM init free of real math at elaboration
    localparam longint PIH_Q30 = 64'sd1686629713;

    function automatic longint lut_entry(input int unsigned out_w,
                                         input int unsigned lut_aw,
                                         input int unsigned k);
        longint x;
        longint x2;
        longint term;
        longint acc;
        longint amp;
        x    = (PIH_Q30 * longint'(2 * k + 1)) >>> (lut_aw + 1);
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int unsigned n = 1; n <= 12; n++) begin
            term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        amp = (longint'(1) <<< (out_w - 1)) - 1;
        return (acc * amp + (longint'(1) <<< 29)) >>> 30;
    endfunction

endpackage

// File: rtl/nco_param_if.sv
// Control and sample bus between the config block, the NCO and the filter datapath.
interface nco_param_if #(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned OUT_W = 16
);
    logic             clken;
    logic [ACC_W-1:0] phi_inc_i;
    logic [ACC_W-1:0] phi_ofs_i;
    logic             cfg_load_i;
    logic             sync_clr_i;
    logic [OUT_W-1:0] fsin_o;
    logic [OUT_W-1:0] fcos_o;
    logic             out_valid;
    logic             wrap_o;

    modport master (
        output clken, phi_inc_i, phi_ofs_i, cfg_load_i, sync_clr_i,
        input  fsin_o, fcos_o, out_valid, wrap_o
    );

    modport slave (
        input  clken, phi_inc_i, phi_ofs_i, cfg_load_i, sync_clr_i,
        output fsin_o, fcos_o, out_valid, wrap_o
    );
endinterface

// File: rtl/nco_qlut.sv
// Dual-read-port registered quarter-wave sine ROM; read registers advance with i_en.
module nco_qlut
    import nco_pkg::*;
#(
    parameter int unsigned OUT_W  = 16,
    parameter int unsigned LUT_AW = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_en,
    input  logic [LUT_AW-1:0] i_addr_a,
    input  logic [LUT_AW-1:0] i_addr_b,
    output logic [OUT_W-1:0]  o_data_a,
    output logic [OUT_W-1:0]  o_data_b
);
    localparam int unsigned DEPTH = 1 << LUT_AW;

    logic [OUT_W-1:0] w_rom [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        localparam logic [OUT_W-1:0] ENTRY = OUT_W'(lut_entry(OUT_W, LUT_AW, g));
        assign w_rom[g] = ENTRY;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_data_a <= '0;
            o_data_b <= '0;
        end else if (i_en) begin
            o_data_a <= w_rom[i_addr_a];
            o_data_b <= w_rom[i_addr_b];
        end
    end

endmodule

// File: rtl/nco_param.sv
// Parametrised phase-accumulator NCO: acc -> phase+offset -> quadrant fold -> LUT -> sign.
// Outputs reflect the accumulator value from four advancing edges earlier.
module nco_param
    import nco_pkg::*;
#(
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned OUT_W  = 16,
    parameter int unsigned LUT_AW = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    nco_param_if.slave  bus
);
    localparam int unsigned IDX_W = LUT_AW + 2;

    logic [ACC_W-1:0]       r_inc;
    logic [ACC_W-1:0]       r_ofs;
    logic [ACC_W-1:0]       r_acc;
    logic                   r_carry;
    logic [IDX_W-1:0]       r_idx;
    logic [LUT_AW-1:0]      r_sadr;
    logic [LUT_AW-1:0]      r_cadr;
    logic                   r_sneg2;
    logic                   r_cneg2;
    logic                   r_sneg3;
    logic                   r_cneg3;
    logic [NCO_LAT-1:1]     r_vld;
    logic [NCO_LAT-1:1]     r_cy;

    logic [ACC_W:0]         w_sum;
    logic [ACC_W-1:0]       w_ph;
    quad_t                  w_qs;
    quad_t                  w_qc;
    logic [LUT_AW-1:0]      w_a;
    logic [OUT_W-1:0]       w_lut_s;
    logic [OUT_W-1:0]       w_lut_c;

    assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};
    assign w_ph  = r_acc + r_ofs;
    assign w_qs  = r_idx[IDX_W-1 -: 2];
    assign w_qc  = w_qs + 2'd1;
    assign w_a   = r_idx[LUT_AW-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inc <= '0;
            r_ofs <= '0;
        end else if (bus.cfg_load_i) begin
            r_inc <= bus.phi_inc_i;
            r_ofs <= bus.phi_ofs_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc   <= '0;
            r_carry <= 1'b0;
        end else if (bus.clken) begin
            if (bus.sync_clr_i) begin
                r_acc   <= '0;
                r_carry <= 1'b0;
            end else begin
                r_acc   <= w_sum[ACC_W-1:0];
                r_carry <= w_sum[ACC_W];
            end
        end
    end

    // Stage 0 valid is a constant 1: the reset accumulator value is itself a sample
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx   <= '0;
            r_sadr  <= '0;
            r_cadr  <= '0;
            r_sneg2 <= 1'b0;
            r_cneg2 <= 1'b0;
            r_sneg3 <= 1'b0;
            r_cneg3 <= 1'b0;
            r_vld   <= '0;
            r_cy    <= '0;
        end else if (bus.clken) begin
            r_idx   <= IDX_W'(w_ph >> (ACC_W - IDX_W));
            r_sadr  <= w_qs[0] ? ~w_a : w_a;
            r_cadr  <= w_qc[0] ? ~w_a : w_a;
            r_sneg2 <= w_qs[1];
            r_cneg2 <= w_qc[1];
            r_sneg3 <= r_sneg2;
            r_cneg3 <= r_cneg2;
            r_vld   <= {r_vld[NCO_LAT-2:1], 1'b1};
            r_cy    <= {r_cy[NCO_LAT-2:1], r_carry};
        end
    end

    nco_qlut #(
        .OUT_W  (OUT_W),
        .LUT_AW (LUT_AW)
    ) u_lut (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_en     (bus.clken),
        .i_addr_a (r_sadr),
        .i_addr_b (r_cadr),
        .o_data_a (w_lut_s),
        .o_data_b (w_lut_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.fsin_o    <= '0;
            bus.fcos_o    <= '0;
            bus.out_valid <= 1'b0;
            bus.wrap_o    <= 1'b0;
        end else if (bus.clken) begin
            bus.fsin_o    <= r_sneg3 ? -w_lut_s : w_lut_s;
            bus.fcos_o    <= r_cneg3 ? -w_lut_c : w_lut_c;
            bus.out_valid <= r_vld[NCO_LAT-1];
            bus.wrap_o    <= r_vld[NCO_LAT-1] & r_cy[NCO_LAT-1];
        end else begin
            bus.out_valid <= 1'b0;
            bus.wrap_o    <= 1'b0;
        end
    end

endmodule
